vector_operand_read: RTL and testbench

Operand-fetch stage of the vector coprocessor, the read-side counterpart of the vector writeback stage. It accepts a decoded vector instruction and issues read addresses to the 4-port vector register file. It gathers the vs2 and vs1 register groups (1 register for LMUL=0, 4 consecutive registers for LMUL=1) into 512-bit operand buses. It presents them to the execute stage with a valid/ready handshake.

---
 rtl/vector_operand_read.sv | 178 +++++++++++++++++
 tb/tb_vector_operand_read.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_operand_read.sv
// Operand-fetch stage: issues vs2/vs1 group reads to the 4-port vector RF and
// presents the gathered 512-bit operand buses to execute via valid/ready.
//
// state     | meaning
// IDLE      | waiting for an instruction, vsi_op_ready=1
// ISSUE_VS2 | reading vs2 group (LMUL=0: vs2 and vs1 together)
// ISSUE_VS1 | capturing vs2 group, reading vs1 group (LMUL=1 only)
// CAPTURE   | capturing the last read data
// VALID     | operands presented, waiting for opr_ready

`ifndef OPC_VREDSUM
`define OPC_VREDSUM 6'b000000
`endif

module vector_operand_read #(
   parameter int VLEN_BITS = 128,
   parameter int NPORT     = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [31:0]                         vsi_op,
   input  logic                                vsi_lmul,
   input  logic                                vsi_sew,
   input  logic                                vsi_op_valid,
   output logic                                vsi_op_ready,
   input  logic                                flush,
   output logic [NPORT-1:0]                    vsi_rf_ren,
   output logic [NPORT-1:0][4:0]               vsi_rf_raddr,
   input  logic [NPORT-1:0][VLEN_BITS-1:0]     vsi_rf_rdata,
   output logic                                opr_valid,
   input  logic                                opr_ready,
   output logic [NPORT*VLEN_BITS-1:0]          vs2_bus,
   output logic [NPORT*VLEN_BITS-1:0]          vs1_bus,
   output logic [31:0]                         opr_op,
   output logic                                opr_lmul,
   output logic                                opr_sew
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ISSUE_VS2 = 3'd1;
   localparam logic [2:0] ISSUE_VS1 = 3'd2;
   localparam logic [2:0] CAPTURE   = 3'd3;
   localparam logic [2:0] VALID     = 3'd4;

   localparam int BUS_W = NPORT * VLEN_BITS;

   logic [2:0]       state_q,   state_d;
   logic [31:0]      op_q,      op_d;
   logic             lmul_q,    lmul_d;
   logic             sew_q,     sew_d;
   logic             vredsum_q, vredsum_d;
   logic             valid_q,   valid_d;
   logic [BUS_W-1:0] vs2_bus_q, vs2_bus_d;
   logic [BUS_W-1:0] vs1_bus_q, vs1_bus_d;

   logic [4:0] vs2_idx;
   logic [4:0] vs1_idx;

   assign vs2_idx = op_q[24:20];
   assign vs1_idx = op_q[19:15];

   assign vsi_op_ready = (state_q == IDLE);
   assign opr_valid    = valid_q;
   assign vs2_bus      = vs2_bus_q;
   assign vs1_bus      = vs1_bus_q;
   assign opr_op       = op_q;
   assign opr_lmul     = lmul_q;
   assign opr_sew      = sew_q;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      lmul_d    = lmul_q;
      sew_d     = sew_q;
      vredsum_d = vredsum_q;
      valid_d   = valid_q;
      vs2_bus_d = vs2_bus_q;
      vs1_bus_d = vs1_bus_q;
      if (flush) begin
         state_d = IDLE;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (vsi_op_valid) begin
                  state_d   = ISSUE_VS2;
                  op_d      = vsi_op;
                  lmul_d    = vsi_lmul;
                  sew_d     = vsi_sew;
                  vredsum_d = (vsi_op[31:26] == `OPC_VREDSUM);
                  vs2_bus_d = '0;
                  vs1_bus_d = '0;
               end
            end
            ISSUE_VS2: state_d = lmul_q ? ISSUE_VS1 : CAPTURE;
            ISSUE_VS1: begin
               vs2_bus_d = vsi_rf_rdata;
               state_d   = CAPTURE;
            end
            CAPTURE: begin
               if (!lmul_q) begin
                  vs2_bus_d[VLEN_BITS-1:0] = vsi_rf_rdata[0];
                  vs1_bus_d[VLEN_BITS-1:0] = vsi_rf_rdata[1];
               end else begin
                  vs1_bus_d[VLEN_BITS-1:0] = vsi_rf_rdata[0];
                  if (!vredsum_q)
                     vs1_bus_d[BUS_W-1:VLEN_BITS] = vsi_rf_rdata[NPORT-1:1];
               end
               state_d = VALID;
               valid_d = 1'b1;
            end
            VALID: begin
               if (opr_ready) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Read ports are decoded from the registered state only; idle ports drive address 0.
   always_comb begin
      vsi_rf_ren   = '0;
      vsi_rf_raddr = '0;
      case (state_q)
         ISSUE_VS2: begin
            if (lmul_q) begin
               for (int k = 0; k < NPORT; k++) begin
                  vsi_rf_ren[k]   = 1'b1;
                  vsi_rf_raddr[k] = vs2_idx + 5'(k);
               end
            end else begin
               vsi_rf_ren[0]   = 1'b1;
               vsi_rf_ren[1]   = 1'b1;
               vsi_rf_raddr[0] = vs2_idx;
               vsi_rf_raddr[1] = vs1_idx;
            end
         end
         ISSUE_VS1: begin
            if (vredsum_q) begin
               vsi_rf_ren[0]   = 1'b1;
               vsi_rf_raddr[0] = vs1_idx;
            end else begin
               for (int k = 0; k < NPORT; k++) begin
                  vsi_rf_ren[k]   = 1'b1;
                  vsi_rf_raddr[k] = vs1_idx + 5'(k);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= '0;
         lmul_q    <= 1'b0;
         sew_q     <= 1'b0;
         vredsum_q <= 1'b0;
         valid_q   <= 1'b0;
         vs2_bus_q <= '0;
         vs1_bus_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         lmul_q    <= lmul_d;
         sew_q     <= sew_d;
         vredsum_q <= vredsum_d;
         valid_q   <= valid_d;
         vs2_bus_q <= vs2_bus_d;
         vs1_bus_q <= vs1_bus_d;
      end
   end

endmodule

// File: tb/tb_vector_operand_read.sv
// Bench for vector_operand_read: RF model, scoreboard of expected operand
// bundles built from register-group rules, directed cases plus random traffic.
module tb_vector_operand_read;

   localparam logic [5:0] VREDSUM = 6'b000000;

   typedef struct {
      logic [31:0]  op;
      logic         lmul;
      logic         sew;
      logic [511:0] vs2;
      logic [511:0] vs1;
      int           vcyc;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [31:0]        vsi_op = '0;
   logic               vsi_lmul = 1'b0;
   logic               vsi_sew = 1'b0;
   logic               vsi_op_valid = 1'b0;
   logic               vsi_op_ready;
   logic               flush = 1'b0;
   logic [3:0]         vsi_rf_ren;
   logic [3:0][4:0]    vsi_rf_raddr;
   logic [3:0][127:0]  vsi_rf_rdata;
   logic               opr_valid;
   logic               opr_ready = 1'b1;
   logic [511:0]       vs2_bus;
   logic [511:0]       vs1_bus;
   logic [31:0]        opr_op;
   logic               opr_lmul;
   logic               opr_sew;

   logic [127:0] rf [32];
   exp_t         sbq [$];
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;

   vector_operand_read #(.VLEN_BITS(128), .NPORT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .vsi_op       (vsi_op),
      .vsi_lmul     (vsi_lmul),
      .vsi_sew      (vsi_sew),
      .vsi_op_valid (vsi_op_valid),
      .vsi_op_ready (vsi_op_ready),
      .flush        (flush),
      .vsi_rf_ren   (vsi_rf_ren),
      .vsi_rf_raddr (vsi_rf_raddr),
      .vsi_rf_rdata (vsi_rf_rdata),
      .opr_valid    (opr_valid),
      .opr_ready    (opr_ready),
      .vs2_bus      (vs2_bus),
      .vs1_bus      (vs1_bus),
      .opr_op       (opr_op),
      .opr_lmul     (opr_lmul),
      .opr_sew      (opr_sew)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Register file: one-cycle synchronous read, garbage on idle ports.
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         vsi_rf_rdata[k] <= vsi_rf_ren[k] ? rf[vsi_rf_raddr[k]]
                                          : {$urandom, $urandom, $urandom, $urandom};
   end

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_op(input logic [5:0] f6, input logic [4:0] vs2,
                                         input logic [4:0] vs1);
      return {f6, 1'b1, vs2, vs1, 3'b010, 5'd7, 7'b1010111};
   endfunction

   // Reference: group of n registers starting at base, wrapping mod 32, packed low-first.
   function automatic logic [511:0] group(input int base, input int n);
      logic [511:0] g = '0;
      for (int k = 0; k < n; k++) g[k*128 +: 128] = rf[(base + k) % 32];
      return g;
   endfunction

   function automatic exp_t model(input logic [31:0] op, input logic lmul, input logic sew);
      exp_t e;
      int n1;
      n1 = !lmul ? 1 : ((op[31:26] == VREDSUM) ? 1 : 4);
      e.op   = op;
      e.lmul = lmul;
      e.sew  = sew;
      e.vs2  = group(int'(op[24:20]), lmul ? 4 : 1);
      e.vs1  = group(int'(op[19:15]), n1);
      e.vcyc = 0;
      return e;
   endfunction

   // Offer an op; returns the cycle number right after the accept edge (period 1).
   task automatic issue(input logic [31:0] op, input logic lmul, input logic sew,
                        input bit push, output int acc);
      int   n;
      exp_t e;
      acc = -1;
      @(negedge clk);
      vsi_op = op; vsi_lmul = lmul; vsi_sew = sew; vsi_op_valid = 1'b1;
      n = 0;
      while (!vsi_op_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!vsi_op_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=not_ready required=ready");
      end else begin
         acc = cyc + 1;
         if (push) begin
            e = model(op, lmul, sew);
            e.vcyc = acc + (lmul ? 3 : 2);
            sbq.push_back(e);
         end
      end
      @(posedge clk);
      #1 vsi_op_valid = 1'b0;
   endtask

   task automatic wait_done(input bit rnd_ready);
      int n = 0;
      while (sbq.size() != 0 && n < 300) begin
         @(negedge clk);
         if (rnd_ready) opr_ready = ($urandom_range(0, 2) != 0);
         n++;
      end
      if (sbq.size() != 0) begin
         checks++; errors++;
         $display("FAIL done_timeout actual=%0d pending required=0", sbq.size());
         sbq.delete();
      end
      @(negedge clk);
      opr_ready = 1'b1;
   endtask

   task automatic chk_rd(input string nm, input logic [3:0] ren,
                         input int a0, input int a1, input int a2, input int a3);
      logic [3:0][4:0] ea;
      ea[0] = 5'(a0); ea[1] = 5'(a1); ea[2] = 5'(a2); ea[3] = 5'(a3);
      chk({nm, "_ren"}, 512'(vsi_rf_ren), 512'(ren));
      chk({nm, "_raddr"}, 512'(vsi_rf_raddr), 512'(ea));
   endtask

   // Monitor: latency on each rising opr_valid, full comparison each valid cycle.
   initial begin
      bit prev = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) prev = 1'b0;
         else begin
            if (opr_valid && !prev) begin
               checks++;
               if (sbq.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_valid actual=1 required=0 at cycle %0d", cyc);
               end else if (cyc != sbq[0].vcyc) begin
                  errors++;
                  $display("FAIL latency actual=%0d required=%0d", cyc, sbq[0].vcyc);
               end
            end
            if (opr_valid && sbq.size() != 0) begin
               chk("opr_op", 512'(opr_op), 512'(sbq[0].op));
               chk("opr_lmul", 512'(opr_lmul), 512'(sbq[0].lmul));
               chk("opr_sew", 512'(opr_sew), 512'(sbq[0].sew));
               chk("vs2_bus", vs2_bus, sbq[0].vs2);
               chk("vs1_bus", vs1_bus, sbq[0].vs1);
               if (opr_ready) void'(sbq.pop_front());
            end
            prev = opr_valid;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_ready"}, 512'(vsi_op_ready), 512'(1));
      chk({nm, "_valid"}, 512'(opr_valid), 512'(0));
      chk({nm, "_ren"}, 512'(vsi_rf_ren), 512'(0));
      chk({nm, "_raddr"}, 512'(vsi_rf_raddr), 512'(0));
      chk({nm, "_vs2"}, vs2_bus, 512'(0));
      chk({nm, "_vs1"}, vs1_bus, 512'(0));
      chk({nm, "_op"}, 512'(opr_op), 512'(0));
      chk({nm, "_lmul_sew"}, 512'({opr_lmul, opr_sew}), 512'(0));
   endtask

   initial begin
      int acc, acc2, rel;
      logic [4:0]  r2, r1;
      logic [5:0]  f6;
      logic        lm, sw;
      for (int n = 0; n < 32; n++) rf[n] = {32{4'(n) + 4'h1}};

      #1 chk_reset_vals("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // LMUL=0, vs2=3, vs1=5
      issue(mk_op(6'b000010, 5'd3, 5'd5), 1'b0, 1'b0, 1'b1, acc);
      @(negedge clk);
      chk_rd("l0_c1", 4'b0011, 3, 5, 0, 0);
      chk("l0_c1_ready", 512'(vsi_op_ready), 512'(0));
      wait_done(1'b0);

      // LMUL=1 with address wrap
      issue(mk_op(6'b000010, 5'd30, 5'd8), 1'b1, 1'b1, 1'b1, acc);
      @(negedge clk);
      chk_rd("l1_c1", 4'b1111, 30, 31, 0, 1);
      @(negedge clk);
      chk_rd("l1_c2", 4'b1111, 8, 9, 10, 11);
      @(negedge clk);
      chk_rd("l1_c3", 4'b0000, 0, 0, 0, 0);
      wait_done(1'b0);

      // LMUL=1 reduction: single vs1 register
      issue(mk_op(VREDSUM, 5'd4, 5'd12), 1'b1, 1'b0, 1'b1, acc);
      @(negedge clk);
      @(negedge clk);
      chk_rd("red_c2", 4'b0001, 12, 0, 0, 0);
      wait_done(1'b0);

      // Backpressure, then a queued LMUL=1 op accepted in the IDLE cycle
      opr_ready = 1'b0;
      issue(mk_op(6'b000101, 5'd9, 5'd2), 1'b0, 1'b1, 1'b1, acc);
      begin
         int n = 0;
         while (!opr_valid && n < 20) begin @(negedge clk); n++; end
      end
      rel = -100;
      fork
         issue(mk_op(6'b000111, 5'd16, 5'd20), 1'b1, 1'b0, 1'b1, acc2);
         begin
            repeat (5) begin
               chk("bp_ready_low", 512'(vsi_op_ready), 512'(0));
               chk("bp_valid_high", 512'(opr_valid), 512'(1));
               @(negedge clk);
            end
            rel = cyc;
            opr_ready = 1'b1;
         end
      join
      chk("bp_next_accept", 512'(acc2), 512'(rel + 2));
      wait_done(1'b0);

      // Flush during ISSUE_VS1
      issue(mk_op(6'b000010, 5'd1, 5'd6), 1'b1, 1'b0, 1'b0, acc);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_ren", 512'(vsi_rf_ren), 512'(0));
      chk("flush_ready", 512'(vsi_op_ready), 512'(1));
      chk("flush_valid", 512'(opr_valid), 512'(0));
      repeat (6) @(negedge clk);
      issue(mk_op(6'b000011, 5'd7, 5'd25), 1'b0, 1'b0, 1'b1, acc);
      wait_done(1'b0);

      // Reset during CAPTURE of an LMUL=1 op
      issue(mk_op(6'b000010, 5'd10, 5'd14), 1'b1, 1'b1, 1'b0, acc);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);

      // Random traffic with fresh RF contents
      for (int n = 0; n < 32; n++) rf[n] = {$urandom, $urandom, $urandom, $urandom};
      for (int t = 0; t < 40; t++) begin
         r2 = 5'($urandom_range(0, 31));
         r1 = 5'($urandom_range(0, 31));
         f6 = ($urandom_range(0, 3) == 0) ? VREDSUM : 6'($urandom_range(1, 63));
         lm = 1'($urandom_range(0, 1));
         sw = 1'($urandom_range(0, 1));
         issue(mk_op(f6, r2, r1), lm, sw, 1'b1, acc);
         wait_done(1'b1);
         if (t % 10 == 9)
            for (int n = 0; n < 32; n++) rf[n] = {$urandom, $urandom, $urandom, $urandom};
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
